// File: rtl/param_latency_ram_pkg.sv
// Shared definitions for the fixed-latency RAM: FSM state encoding and
// default parameter values used by the top level and its storage array.
package param_latency_ram_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/param_latency_ram_array.sv
// Word-organised storage with byte-enabled synchronous write and a
// registered read port; only the read register is affected by reset.
module ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array has no reset branch; clearing it would turn the
  // RAM into a flop bank and contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_latency_ram.sv
// Single-port RAM that completes every request exactly LATENCY cycles after
// acceptance; the storage is touched only on the edge that enters DONE.
module param_latency_ram
  import param_latency_ram_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                busy,
  output logic                isFinish
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [BE_W-1:0]    be_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               accept;
  logic               mem_en;
  logic               mem_we;
  logic [BE_W-1:0]    mem_be;
  logic [ADDR_W-1:0]  mem_idx;
  logic [DATA_W-1:0]  mem_wdata;
  logic               addr_unused;

  assign accept      = (state_q == IDLE) && en;
  assign addr_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches are only consumed after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      be_q    <= be;
      idx_q   <= addr[ADDR_W+1:2];
      wdata_q <= data_in;
    end
  end

  // With LATENCY=1 the access happens on the acceptance edge itself, before
  // the latches hold the request, so the live inputs feed the array then.
  always_comb begin
    mem_we    = we_q;
    mem_be    = be_q;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;
    if (state_q == IDLE) begin
      mem_we    = we;
      mem_be    = be;
      mem_idx   = addr[ADDR_W+1:2];
      mem_wdata = data_in;
    end
  end

  assign mem_en = (state_d == DONE) && !rst;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (data_out)
  );

  assign busy     = (state_q != IDLE);
  assign isFinish = (state_q == DONE);

endmodule

// File: tb/tb_param_latency_ram.sv
// Directed bench driving three configurations of param_latency_ram:
// defaults (LATENCY=8), LATENCY=3, and ADDR_W=4 with LATENCY=1.
module tb_param_latency_ram;

  localparam int LAT [3] = '{8, 3, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        en_v   [3];
  logic        we_v   [3];
  logic [3:0]  be_v   [3];
  logic [31:0] addr_v [3];
  logic [31:0] din_v  [3];
  logic [31:0] dout_v [3];
  logic        busy_v [3];
  logic        fin_v  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_latency_ram u_l8 (
    .clk(clk), .rst(rst), .en(en_v[0]), .we(we_v[0]), .be(be_v[0]),
    .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout_v[0]),
    .busy(busy_v[0]), .isFinish(fin_v[0])
  );

  param_latency_ram #(.DATA_W(32), .ADDR_W(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .en(en_v[1]), .we(we_v[1]), .be(be_v[1]),
    .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout_v[1]),
    .busy(busy_v[1]), .isFinish(fin_v[1])
  );

  param_latency_ram #(.DATA_W(32), .ADDR_W(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en(en_v[2]), .we(we_v[2]), .be(be_v[2]),
    .addr(addr_v[2]), .data_in(din_v[2]), .data_out(dout_v[2]),
    .busy(busy_v[2]), .isFinish(fin_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from posedge+1, scrambles inputs after acceptance and
  // checks busy, completion latency and the single-cycle isFinish pulse.
  task automatic do_req(input int d, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] data, input string tag);
    int n;
    en_v[d] = 1'b1; we_v[d] = w; be_v[d] = b; addr_v[d] = a; din_v[d] = data;
    @(posedge clk); #1;
    en_v[d] = 1'b0; we_v[d] = ~w; be_v[d] = ~b; addr_v[d] = ~a; din_v[d] = ~data;
    check({tag, "_busy"}, 32'(busy_v[d]), 32'd1);
    n = 1;
    while (!fin_v[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, LAT[d]);
    @(posedge clk); #1;
    check({tag, "_fin_off"}, 32'(fin_v[d]), 32'd0);
    check({tag, "_idle"}, 32'(busy_v[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] busy_bits;
    logic [11:0] fin_bits;
    logic        saw_fin;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en_v[d] = 1'b0; we_v[d] = 1'b0; be_v[d] = 4'h0; addr_v[d] = '0; din_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dout", dout_v[0], 32'h0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_fin", 32'(fin_v[0]), 32'd0);

    // Full-word write then read back at LATENCY=8.
    do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr10");
    check("dout_hold_on_write", dout_v[0], 32'h0);
    do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, "rd10");
    check("rd10_data", dout_v[0], 32'hDEADBEEF);

    // Byte-enable merge, then an all-zero byte-enable write.
    do_req(0, 1'b1, 4'hF, 32'h14, 32'h11223344, "wr14");
    do_req(0, 1'b1, 4'b0101, 32'h14, 32'hAABBCCDD, "wr14_be");
    check("dout_hold_after_writes", dout_v[0], 32'hDEADBEEF);
    do_req(0, 1'b0, 4'hF, 32'h14, 32'h0, "rd14");
    check("rd14_merge", dout_v[0], 32'h11BB33DD);
    do_req(0, 1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, "wr14_be0");
    do_req(0, 1'b0, 4'hF, 32'h14, 32'h0, "rd14_again");
    check("rd14_be0_unchanged", dout_v[0], 32'h11BB33DD);

    // Reset aborts an in-flight write; memory keeps the prior word.
    do_req(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, "wr20");
    en_v[0] = 1'b1; we_v[0] = 1'b1; be_v[0] = 4'hF; addr_v[0] = 32'h20; din_v[0] = 32'h0BADBEEF;
    @(posedge clk); #1;
    en_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_fin", 32'(fin_v[0]), 32'd0);
    check("abort_dout_cleared", dout_v[0], 32'h0);
    rst = 1'b0;
    saw_fin = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_fin = saw_fin | fin_v[0];
    end
    check("abort_no_fin", 32'(saw_fin), 32'd0);

    // Request on the very first edge after reset deasserts.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, "rd20_after_rst");
    check("rd20_prior", dout_v[0], 32'hCAFEF00D);

    // LATENCY=3 with en held high and inputs changing every cycle.
    do_req(1, 1'b1, 4'hF, 32'h4, 32'h0, "l3_pre4");
    en_v[1] = 1'b1; we_v[1] = 1'b1; be_v[1] = 4'hF; addr_v[1] = 32'h0; din_v[1] = 32'hA0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      busy_bits[c] = busy_v[1];
      fin_bits[c]  = fin_v[1];
      addr_v[1] = 32'((c + 1) * 4);
      din_v[1]  = 32'hA0 + 32'(c + 1);
    end
    en_v[1] = 1'b0;
    check("l3_busy_pattern", 32'(busy_bits), 32'h777);
    check("l3_fin_pattern", 32'(fin_bits), 32'h444);
    do_req(1, 1'b0, 4'hF, 32'h0, 32'h0, "l3_rd0");
    check("l3_rd0_data", dout_v[1], 32'hA0);
    do_req(1, 1'b0, 4'hF, 32'h4, 32'h0, "l3_rd4");
    check("l3_rd4_ignored", dout_v[1], 32'h0);
    do_req(1, 1'b0, 4'hF, 32'h10, 32'h0, "l3_rd16");
    check("l3_rd16_data", dout_v[1], 32'hA4);
    do_req(1, 1'b0, 4'hF, 32'h20, 32'h0, "l3_rd32");
    check("l3_rd32_data", dout_v[1], 32'hA8);

    // ADDR_W=4, LATENCY=1: address wrap.
    do_req(2, 1'b1, 4'hF, 32'h40, 32'h5, "l1_wr40");
    do_req(2, 1'b0, 4'hF, 32'h00, 32'h0, "l1_rd00");
    check("l1_wrap_data", dout_v[2], 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
